// File: rtl/game_pkg.sv
// Shared game types: block geometry, colours, directions and
// the active-video constants used by block_selector and renderer.
package game_pkg;

  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 720;

  typedef enum logic [2:0] {
    UP,
    RIGHT,
    DOWN,
    LEFT,
    ANY
  } direction_t;

  typedef enum logic {
    BLUE,
    RED
  } block_color_t;

  typedef struct packed {
    logic [11:0]  x;
    logic [11:0]  y;
    logic [13:0]  z;
    block_color_t color;
    direction_t   direction;
  } block_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } sel_state_t;

endpackage

// File: rtl/block_selector_if.sv
// Block table write port: valid/ready handshake plus the
// fields of one table entry.
interface block_selector_if;

  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_idx;
  logic [11:0] wr_x;
  logic [11:0] wr_y;
  logic [13:0] wr_z;
  logic        wr_color;
  logic [2:0]  wr_direction;
  logic        wr_visible;

  modport master (
    output wr_valid,
    output wr_idx,
    output wr_x,
    output wr_y,
    output wr_z,
    output wr_color,
    output wr_direction,
    output wr_visible,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_idx,
    input  wr_x,
    input  wr_y,
    input  wr_z,
    input  wr_color,
    input  wr_direction,
    input  wr_visible,
    output wr_ready
  );

endinterface

// File: rtl/span_check.sv
// Signed distance test |a - c| <= HALF on zero-extended
// 12-bit coordinates.
module span_check #(
  parameter int HALF = 32
) (
  input  logic [11:0] a_i,
  input  logic [11:0] c_i,
  output logic        ok_o
);

  logic signed [12:0] diff;
  logic        [12:0] mag;

  assign diff = $signed({1'b0, a_i})
              - $signed({1'b0, c_i});
  assign mag  = diff[12] ? $unsigned(-diff)
                         : $unsigned(diff);
  assign ok_o = (mag <= 13'(HALF));

endmodule

// File: rtl/block_selector.sv
// Per-pixel nearest-block source for renderer: block table,
// blanking-time scanline scan and 1-cycle pixel select.
module block_selector
  import game_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int LINE_SLOTS = 4,
  parameter int BLOCK_HALF = 32,
  parameter int H_ACTIVE   = game_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = game_pkg::V_ACTIVE
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [10:0]      x_in,
  input  logic [9:0]       y_in,
  block_selector_if.slave  wr,
  output logic [11:0]      block_x,
  output logic [11:0]      block_y,
  output logic [13:0]      block_z,
  output logic             block_color,
  output logic [2:0]       block_direction,
  output logic             block_visible,
  output logic [10:0]      x_out,
  output logic [9:0]       y_out,
  output logic             line_overflow
);

  localparam int IW = $clog2(NUM_BLOCKS);
  localparam int SW = $clog2(LINE_SLOTS);
  localparam int CW = $clog2(LINE_SLOTS + 1);

  block_t                  tbl_q [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0]   live_q;

  sel_state_t              state_q;
  logic [IW-1:0]           idx_q;
  logic [11:0]             ty_q;
  logic [11:0]             ty_d;
  logic [CW-1:0]           cnt_q;
  logic                    ovf_q;
  logic                    lovf_q;
  block_t                  shd_q [LINE_SLOTS];
  logic [LINE_SLOTS-1:0]   shd_v_q;
  block_t                  act_q [LINE_SLOTS];
  logic [LINE_SLOTS-1:0]   act_v_q;

  block_t                  cur;
  logic                    scan_span;
  logic                    scan_hit;
  logic                    full;
  logic                    wr_fire;

  logic [LINE_SLOTS-1:0]   px_span;
  logic [LINE_SLOTS-1:0]   px_hit;
  block_t                  win_d;
  logic                    vis_d;
  block_t                  blk_q;
  logic                    vis_q;
  logic [10:0]             x_q;
  logic [9:0]              y_q;

  assign wr.wr_ready = (state_q == IDLE);
  assign wr_fire     = wr.wr_valid && wr.wr_ready;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      live_q <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++)
        tbl_q[i] <= '0;
    end else if (wr_fire) begin
      tbl_q[wr.wr_idx[IW-1:0]] <= '{
        x:         wr.wr_x,
        y:         wr.wr_y,
        z:         wr.wr_z,
        color:     block_color_t'(wr.wr_color),
        direction: direction_t'(wr.wr_direction)
      };
      live_q[wr.wr_idx[IW-1:0]] <= wr.wr_visible;
    end
  end

  assign cur  = tbl_q[idx_q];
  assign ty_d = (y_in == 10'(V_ACTIVE - 1))
              ? 12'd0 : {2'b00, y_in} + 12'd1;
  assign full = (cnt_q == CW'(LINE_SLOTS));

  span_check #(.HALF(BLOCK_HALF)) u_scan (
    .a_i  (ty_q),
    .c_i  (cur.y),
    .ok_o (scan_span)
  );

  // A zero-depth entry is treated as not present.
  assign scan_hit = live_q[idx_q]
                 && (cur.z != '0)
                 && scan_span;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ty_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      lovf_q  <= 1'b0;
      shd_v_q <= '0;
      act_v_q <= '0;
      for (int s = 0; s < LINE_SLOTS; s++) begin
        shd_q[s] <= '0;
        act_q[s] <= '0;
      end
    end else begin
      lovf_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (x_in == 11'(H_ACTIVE)) begin
            state_q <= SCAN;
            ty_q    <= ty_d;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            shd_v_q <= '0;
          end
        end
        SCAN: begin
          if (scan_hit) begin
            if (!full) begin
              shd_q[cnt_q[SW-1:0]]   <= cur;
              shd_v_q[cnt_q[SW-1:0]] <= 1'b1;
              cnt_q <= cnt_q + 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
          end
          if (idx_q == IW'(NUM_BLOCKS - 1))
            state_q <= COMMIT;
          else
            idx_q <= idx_q + 1'b1;
        end
        COMMIT: begin
          act_q   <= shd_q;
          act_v_q <= shd_v_q;
          lovf_q  <= ovf_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < LINE_SLOTS; g++) begin : g_px
    span_check #(.HALF(BLOCK_HALF)) u_px (
      .a_i  ({1'b0, x_in}),
      .c_i  (act_q[g].x),
      .ok_o (px_span[g])
    );
    assign px_hit[g] = act_v_q[g] && px_span[g];
  end

  // Strict less-than keeps the lower slot on equal depth.
  always_comb begin
    win_d = '0;
    vis_d = 1'b0;
    for (int s = 0; s < LINE_SLOTS; s++) begin
      if (px_hit[s] && (!vis_d || act_q[s].z < win_d.z)) begin
        win_d = act_q[s];
        vis_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      blk_q <= '0;
      vis_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      blk_q <= win_d;
      vis_q <= vis_d;
      x_q   <= x_in;
      y_q   <= y_in;
    end
  end

  assign block_x         = blk_q.x;
  assign block_y         = blk_q.y;
  assign block_z         = blk_q.z;
  assign block_color     = blk_q.color;
  assign block_direction = blk_q.direction;
  assign block_visible   = vis_q;
  assign x_out           = x_q;
  assign y_out           = y_q;
  assign line_overflow   = lovf_q;

endmodule

// File: tb/tb_block_selector.sv
// Directed bench for block_selector with a pixel scoreboard.
module tb_block_selector;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic [11:0] bx, by;
  logic [13:0] bz;
  logic        bc;
  logic [2:0]  bd;
  logic        bvis;
  logic [10:0] xo;
  logic [9:0]  yo;
  logic        lovf;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q [$];
  string       tag_q [$];

  int   r, o;
  logic a;

  block_selector_if wr_if ();

  block_selector dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .x_in            (x_in),
    .y_in            (y_in),
    .wr              (wr_if),
    .block_x         (bx),
    .block_y         (by),
    .block_z         (bz),
    .block_color     (bc),
    .block_direction (bd),
    .block_visible   (bvis),
    .x_out           (xo),
    .y_out           (yo),
    .line_overflow   (lovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {bvis, bx, by, bz, bc, bd, xo, yo};
  endfunction

  task automatic px(input logic [10:0] x,
                    input logic [9:0]  y,
                    input logic        v,
                    input logic [11:0] ex,
                    input logic [11:0] ey,
                    input logic [13:0] ez,
                    input logic        ec,
                    input logic [2:0]  ed,
                    input string       tag);
    logic [63:0] e;
    string       t;
    x_in = x;
    y_in = y;
    exp_q.push_back({v, ex, ey, ez, ec, ed, x, y});
    tag_q.push_back(tag);
    tick;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, outs(), e);
  endtask

  task automatic px_none(input logic [10:0] x,
                         input logic [9:0]  y,
                         input string       tag);
    px(x, y, 1'b0, '0, '0, '0, 1'b0, '0, tag);
  endtask

  task automatic set_wr(input logic [2:0]  idx,
                        input logic [11:0] x,
                        input logic [11:0] y,
                        input logic [13:0] z,
                        input logic        c,
                        input logic [2:0]  d,
                        input logic        v);
    wr_if.wr_idx       = idx;
    wr_if.wr_x         = x;
    wr_if.wr_y         = y;
    wr_if.wr_z         = z;
    wr_if.wr_color     = c;
    wr_if.wr_direction = d;
    wr_if.wr_visible   = v;
  endtask

  task automatic wr(input logic [2:0]  idx,
                    input logic [11:0] x,
                    input logic [11:0] y,
                    input logic [13:0] z,
                    input logic        c,
                    input logic [2:0]  d,
                    input logic        v);
    int n;
    n = 0;
    x_in = 11'd0;
    set_wr(idx, x, y, z, c, d, v);
    wr_if.wr_valid = 1'b1;
    while (!wr_if.wr_ready && n < 40) begin
      tick;
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $error("FAIL wr_timeout: ready 0 expected 1");
    end
    tick;
    wr_if.wr_valid = 1'b0;
  endtask

  // Triggers a scan for target row y+1 and watches it.
  task automatic scan(input  logic [9:0] y,
                      input  logic       do_wr,
                      output int         rdy0,
                      output int         ovf,
                      output logic       acc);
    logic take;
    rdy0 = 0;
    ovf  = 0;
    acc  = 1'b0;
    x_in = 11'd1280;
    y_in = y;
    tick;
    x_in = 11'd1281;
    if (do_wr) wr_if.wr_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (!wr_if.wr_ready) rdy0++;
      if (lovf) ovf++;
      take = wr_if.wr_valid && wr_if.wr_ready;
      tick;
      if (take) begin
        wr_if.wr_valid = 1'b0;
        acc = 1'b1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish, limit 2000000");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    x_in = '0;
    y_in = '0;
    wr_if.wr_valid = 1'b0;
    set_wr(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    chk("reset_outs", outs(), 64'd0);
    chk("reset_ready", 64'(wr_if.wr_ready), 64'd1);
    chk("reset_ovf", 64'(lovf), 64'd0);
    rst = 1'b0;
    px_none(640, 360, "reset_px_a");
    px_none(0, 0, "reset_px_b");

    wr(0, 640, 360, 100, 1, 0, 1);
    scan(359, 0, r, o, a);
    chk("scan_ready_low", 64'(r), 64'd9);
    chk("scan_no_ovf", 64'(o), 64'd0);
    px(640, 360, 1, 640, 360, 100, 1, 0, "single_centre");
    px_none(673, 360, "single_x_beyond");
    px(672, 360, 1, 640, 360, 100, 1, 0, "single_x_edge");
    px(608, 360, 1, 640, 360, 100, 1, 0, "single_x_ledge");
    px_none(607, 360, "single_x_lbeyond");

    scan(326, 0, r, o, a);
    px_none(640, 327, "y_beyond");
    scan(327, 0, r, o, a);
    px(640, 328, 1, 640, 360, 100, 1, 0, "y_edge");
    px(640, 329, 1, 640, 360, 100, 1, 0, "retained_row");

    wr(7, 100, 20, 5, 0, 4, 1);
    scan(719, 0, r, o, a);
    px(100, 0, 1, 100, 20, 5, 0, 4, "wrap_row0");

    wr(0, 400, 200, 200, 0, 1, 1);
    wr(1, 410, 200, 100, 0, 2, 1);
    scan(199, 0, r, o, a);
    px(405, 200, 1, 410, 200, 100, 0, 2, "depth_near");
    px(370, 200, 1, 400, 200, 200, 0, 1, "depth_single");
    wr(0, 400, 200, 100, 1, 3, 1);
    scan(199, 0, r, o, a);
    px(405, 200, 1, 400, 200, 100, 1, 3, "depth_tie");

    for (int i = 0; i < 6; i++)
      wr(3'(i), 12'(100 * (i + 1)), 300, 10, 0, 4, 1);
    scan(299, 0, r, o, a);
    chk("ovf_pulse", 64'(o), 64'd1);
    chk("ovf_ready_low", 64'(r), 64'd9);
    for (int i = 0; i < 4; i++)
      px(11'(100 * (i + 1)), 300, 1,
         12'(100 * (i + 1)), 300, 10, 0, 4, "ovf_kept");
    px_none(500, 300, "ovf_drop_500");
    px_none(600, 300, "ovf_drop_600");

    set_wr(6, 900, 500, 7, 1, 4, 1);
    scan(499, 1, r, o, a);
    chk("wds_ready_low", 64'(r), 64'd9);
    chk("wds_accepted", 64'(a), 64'd1);
    px_none(900, 500, "wds_not_yet");
    scan(499, 0, r, o, a);
    px(900, 500, 1, 900, 500, 7, 1, 4, "wds_visible");

    x_in = 11'd1280;
    y_in = 10'd499;
    tick;
    x_in = 11'd1281;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_ready", 64'(wr_if.wr_ready), 64'd1);
    px_none(900, 500, "midrst_px");
    scan(499, 0, r, o, a);
    px_none(900, 500, "midrst_empty_a");
    scan(299, 0, r, o, a);
    px_none(100, 300, "midrst_empty_b");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
